// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants and helpers for the 7-segment scan controller
//
// Contents:
//   NUM_DIGITS_DEF / TICK_DIV_DEF / BLANK_CYCLES_DEF : default parameter values
//   ST_BLANK / ST_SHOW                                : scan FSM state encodings
//   DIGIT_OFF                                         : level that turns a digit off (active-low select)
//   idx_width()                                       : width of a digit index for n digits
package sevenseg_pkg;

    localparam int NUM_DIGITS_DEF   = 4;
    localparam int TICK_DIV_DEF     = 50000;
    localparam int BLANK_CYCLES_DEF = 500;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic DIGIT_OFF = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sevenseg_tick_gen.sv
// rtl/sevenseg_tick_gen.sv - digit-slot prescaler producing blank-end and slot-end pulses
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   blank_end_o  out  high in the last cycle of the blanking gap (prescaler == BLANK_CYCLES-1)
//   slot_end_o   out  high in the last cycle of a digit slot (prescaler == TICK_DIV-1)
module sevenseg_tick_gen #(
    parameter int TICK_DIV     = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic blank_end_o,
    output logic slot_end_o
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] presc_d;

    always_comb begin
        slot_end_o  = (presc_q == SLOT_LAST);
        blank_end_o = (presc_q == BLANK_LAST);
        presc_d     = slot_end_o ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/sevenseg.sv
// rtl/sevenseg.sv - time-multiplexed 4-digit hex display scan controller (top: sevenseg_scan)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   value_in     in   value to display, nibble 0 = value_in[3:0] = rightmost digit
//   load         in   single-cycle strobe capturing value_in/dp_in into the shadow buffer
//   dp_in        in   per-digit decimal point request, captured with value_in
//   nibble_out   out  current digit's nibble for the downstream decoder
//   dp_out       out  decimal point for the current digit, active-high
//   digit_sel    out  active-low one-hot digit enable
//   frame_start  out  one-cycle pulse in the cycle after the digit index wraps to 0
//
// Build option: define SEVENSEG_LZS_EN for leading-zero suppression.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              nibble_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic blank_end;
    logic slot_end;

    // The FSM and the prescaler leave reset together, so the FSM is always
    // in BLANK when blank_end fires and in SHOW when slot_end fires.
    sevenseg_tick_gen #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .blank_end_o (blank_end),
        .slot_end_o  (slot_end)
    );

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [VAL_W-1:0]      disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                  pending_q, pending_d;
    logic [3:0]            nibble_q, nibble_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  fs_q, fs_d;
    logic                  wrap;

    // Scan sequencing: BLANK gap, then SHOW until the slot ends.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        if (state_q == ST_BLANK) begin
            if (blank_end) begin
                state_d = ST_SHOW;
            end
        end else begin
            if (slot_end) begin
                state_d = ST_BLANK;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    // Double buffer: loads land in the shadow; the display copy only changes
    // on the frame wrap so a frame never mixes old and new digits. A load on
    // the wrap cycle itself goes straight to the display.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;
        if (load) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
        if (wrap) begin
            if (load) begin
                disp_val_d = value_in;
                disp_dp_d  = dp_in;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
            end
            pending_d = 1'b0;
        end
    end

`ifdef SEVENSEG_LZS_EN
    // zero_above[i]: nibbles and dp bits i..NUM_DIGITS-1 are all clear.
    logic [NUM_DIGITS-1:0] zero_above;

    always_comb begin : lzs_scan
        logic run;
        run        = 1'b1;
        zero_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run           = run & (disp_val_d[4*i +: 4] == 4'd0) & ~disp_dp_d[i];
            zero_above[i] = run;
        end
    end
`endif

    // Outputs are computed from next-state values so all three change on
    // the same edge as the index/state they describe.
    always_comb begin
        nibble_d = disp_val_d[{idx_d, 2'b00} +: 4];
        dp_d     = disp_dp_d[idx_d];
        fs_d     = wrap;
        sel_d    = {NUM_DIGITS{DIGIT_OFF}};
        if (state_d == ST_SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEVENSEG_LZS_EN
                if ((idx_d == IDX_W'(i)) && !((i != 0) && zero_above[i])) begin
                    sel_d[i] = ~DIGIT_OFF;
                end
`else
                if (idx_d == IDX_W'(i)) begin
                    sel_d[i] = ~DIGIT_OFF;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            nibble_q     <= 4'd0;
            dp_q         <= 1'b0;
            sel_q        <= {NUM_DIGITS{DIGIT_OFF}};
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            fs_q         <= fs_d;
        end
    end

    assign nibble_out  = nibble_q;
    assign dp_out      = dp_q;
    assign digit_sel   = sel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - scoreboard testbench for sevenseg_scan
module tb_sevenseg_scan;

    localparam int ND    = 4;
    localparam int TD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * TD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  nibble_out;
    logic        dp_out;
    logic [3:0]  digit_sel;
    logic        frame_start;

    always #5 clk = ~clk;

    sevenseg_scan #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .load        (load),
        .dp_in       (dp_in),
        .nibble_out  (nibble_out),
        .dp_out      (dp_out),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic [3:0]  nib;
        logic        dp;
        logic        fs;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          load_cyc[$];
    logic [15:0] load_v[$];
    logic [3:0]  load_d[$];
    int          tests = 0;
    int          fails = 0;
    int          t     = 0;

    // Value shown during a frame: the latest load issued before that frame began.
    function automatic logic [19:0] model_disp(input int frame);
        logic [19:0] r;
        r = 20'd0;
        for (int i = 0; i < load_cyc.size(); i++) begin
            if (load_cyc[i] <= FRAME * frame - 1) r = {load_v[i], load_d[i]};
        end
        return r;
    endfunction

    function automatic exp_t model_out(input int tc);
        exp_t        e;
        logic [19:0] dsp;
        logic [15:0] v;
        logic [3:0]  d;
        int          slot;
        int          phase;
        logic        lit;
        slot  = (tc / TD) % ND;
        phase = tc % TD;
        dsp   = model_disp(tc / FRAME);
        v     = dsp[19:4];
        d     = dsp[3:0];
        e.nib = 4'((v >> (4 * slot)) & 16'h000F);
        e.dp  = d[slot];
        e.fs  = (tc > 0) && (tc % FRAME == 0);
        e.sel = 4'hF;
        if (phase >= BC) begin
            lit = 1'b1;
`ifdef SEVENSEG_LZS_EN
            if (slot > 0 && (v >> (4 * slot)) == 16'd0 && (d >> slot) == 4'd0) lit = 1'b0;
`endif
            if (lit) e.sel = ~(4'b0001 << slot);
        end
        e.cyc = 32'(tc);
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
        @(posedge clk);
        #1;
        t++;
        load     = ld;
        value_in = v;
        dp_in    = d;
        if (ld) begin
            load_cyc.push_back(t);
            load_v.push_back(v);
            load_d.push_back(d);
        end
        exp_q.push_back(model_out(t));
    endtask

    task automatic idle_to(input int n);
        while (t < n - 1) step(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load  = 1'b0;
        t     = 0;
        exp_q.push_back(model_out(0));
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b1;
        value_in = 16'hFFFF;
        dp_in    = 4'hF;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        tests++;
                        if ({digit_sel, nibble_out, dp_out, frame_start} !== {e.sel, e.nib, e.dp, e.fs}) begin
                            fails++;
                            $display("FAIL cycle %0d: sel=%b nib=%h dp=%b fs=%b, expected sel=%b nib=%h dp=%b fs=%b",
                                     e.cyc, digit_sel, nibble_out, dp_out, frame_start, e.sel, e.nib, e.dp, e.fs);
                        end
                    end
                end
            end
            begin : stimulus
                repeat (3) @(posedge clk);
                #1;
                check("reset_sel", {4'd0, digit_sel}, 8'h0F);
                check("reset_nib", {4'd0, nibble_out}, 8'h00);
                check("reset_dp", {7'd0, dp_out}, 8'h00);
                check("reset_fs", {7'd0, frame_start}, 8'h00);
                release_reset();

                idle_to(20);
                step(1'b1, 16'hA5C3, 4'b0000);
                idle_to(100);
                step(1'b1, 16'h1234, 4'b0010);
                idle_to(110);
                step(1'b1, 16'h5678, 4'b1000);
                idle_to(7 * FRAME - 1);
                step(1'b1, 16'hBEEF, 4'b0101);
                idle_to(300);

                repeat (640) begin
                    if ($urandom_range(0, 19) == 0) begin
                        logic [15:0] rv;
                        logic [3:0]  rd;
                        case ($urandom_range(0, 2))
                            0:       rv = 16'($urandom);
                            1:       rv = 16'($urandom_range(0, 255));
                            default: rv = 16'd0;
                        endcase
                        rd = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
                        step(1'b1, rv, rd);
                    end else begin
                        step(1'b0, 16'($urandom), 4'($urandom));
                    end
                end

                step(1'b1, 16'h9ABC, 4'b1111);
                while ((t + 1) % FRAME != 3 * TD + 4) step(1'b0, 16'h0, 4'h0);
                idle_n(FRAME);
                step(1'b0, 16'h0, 4'h0);
                #2;
                rst_n = 1'b0;
                exp_q.delete();
                #1;
                check("midreset_sel", {4'd0, digit_sel}, 8'h0F);
                check("midreset_nib", {4'd0, nibble_out}, 8'h00);
                check("midreset_dp", {7'd0, dp_out}, 8'h00);
                load_cyc.delete();
                load_v.delete();
                load_d.delete();
                load     = 1'b1;
                value_in = 16'hFFFF;
                dp_in    = 4'hF;
                release_reset();
                idle_n(2 * FRAME + 6);

                step(1'b1, 16'h0042, 4'b0000);
                idle_n(3 * FRAME);
                step(1'b1, 16'h0000, 4'b0000);
                idle_n(3 * FRAME);
                @(negedge clk);
                #1;
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Time-multiplexed scan controller for the 4-digit common-anode hex display. Captures a 16-bit debug value (CPU address/data bus) on a load strobe into a double buffer. Each digit slot presents one nibble to the downstream 7-segment decoder and drives the matching active-low digit select, with an inter-digit blanking gap to prevent ghosting. Buffered values are swapped in only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; value width is 4*NUM_DIGITS.
TICK_DIV, 50000, clock cycles per digit slot (1 ms at 50 MHz); must be >= 2.
BLANK_CYCLES, 500, cycles at the start of each slot with all digits off; must be >= 1 and < TICK_DIV.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
value_in  in  4*NUM_DIGITS  value to display; nibble 0 is value_in[3:0] and is the rightmost digit.
load  in  1  single-cycle strobe; captures value_in into the shadow register.
dp_in  in  NUM_DIGITS  per-digit decimal point request; captured with value_in.
nibble_out  out  4  current digit's nibble; feeds the decoder input.
dp_out  out  1  decimal point for the current digit, active-high.
digit_sel  out  NUM_DIGITS  active-low one-hot digit enable.
frame_start  out  1  one-cycle pulse when digit index wraps to 0.

Behaviour:
- Reset (async assert, sync release): prescaler=0, digit index=0, state=BLANK, shadow/display/dp registers=0, pending=0, nibble_out=0, dp_out=0, digit_sel=all ones, frame_start=0.
- Prescaler counts 0..TICK_DIV-1 and wraps. The slot-end tick is asserted when prescaler==TICK_DIV-1.
- FSM states:
  - BLANK: digit_sel=all ones; nibble_out/dp_out already show the current index. Go to SHOW when prescaler==BLANK_CYCLES-1.
  - SHOW: digit_sel[idx]=0, all other bits 1. On tick, advance idx and go to BLANK.
- Index advance: idx <= idx+1, wrapping NUM_DIGITS-1 -> 0. The wrap cycle is the frame boundary; frame_start is registered and is high in the cycle after the wrap.
- All outputs are registered; nibble_out, dp_out and digit_sel change on the same edge.
- load: shadow <= {value_in, dp_in}; pending <= 1.
- Frame boundary with pending=1: display <= shadow; pending <= 0.
- Simultaneous load and frame boundary: value_in/dp_in are written to both shadow and display; pending ends at 0.
- Back-to-back loads within a frame: the last one wins; the earlier ones are never displayed.
- Latency: a loaded value first appears in the slot for digit 0 that follows the next frame boundary. Worst case is NUM_DIGITS*TICK_DIV+1 cycles.
- load while rst_n is low is ignored. Reset mid-frame immediately blanks all digits.

Optional Feature:
SEVENSEG_LZS_EN: leading-zero suppression.
- Defined: in SHOW, digit i (i>0) stays off (digit_sel all ones) when display nibbles i..NUM_DIGITS-1 are all zero and dp for those digits is 0. Digit 0 is always shown. Timing is unchanged.
- Undefined: every digit is shown; there is no extra logic.

Decomposition:
- Package sevenseg_pkg: FSM state enum (BLANK, SHOW); default constants for TICK_DIV, BLANK_CYCLES, NUM_DIGITS; the active-low digit-off constant.
- One sub-module is natural: sevenseg_tick_gen, holding the prescaler and producing the blank_end and slot_end pulses.
- Index, FSM, double buffer and LZS logic stay in sevenseg_scan.

Test Plan (NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2):
1. Reset release, no load -> digit_sel=1111 for 2 cycles, then 1110 for 6 cycles, then 1111/1101 and so on. nibble_out=0 throughout. frame_start pulses every 32 cycles.
2. load with value_in=16'hA5C3 in the middle of digit 2 -> digits keep showing 0 until the boundary. Then nibble_out reads 3, C, 5, A across the four slots, with digit_sel=1110, 1101, 1011, 0111 in the SHOW phases.
3. load 16'h1234, then load 16'h5678 in the same frame -> only 8, 7, 6, 5 are ever displayed.
4. load asserted exactly on the wrap cycle with 16'hBEEF -> F is shown in the immediately following digit-0 slot, and pending reads 0 afterwards.
5. rst_n asserted low for 1 cycle during SHOW of digit 3 -> digit_sel=1111 within the same cycle (async), and display is cleared to 0.
6. With SEVENSEG_LZS_EN and value 16'h0042 -> digits 3 and 2 stay at 1111 during SHOW, digits 1 and 0 show 4 and 2. With 16'h0000, only digit 0 lights, showing 0.
